// File: rtl/vreg_read_stage.sv
// VRF read stage: turns address-generator beats into VRF reads, follows the
// fixed read latency with a sideband pipe and buffers beats in a credit FIFO.
module vreg_read_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int VL_WIDTH   = 15,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [OFF_WIDTH-1:0]    req_off,
  input  logic                    req_start,
  input  logic                    req_end,
  input  logic [VL_WIDTH-1:0]     vl,
  input  logic [1:0]              sew,
  output logic                    vrf_rd_en,
  output logic [ADDR_WIDTH-1:0]   vrf_rd_addr,
  output logic [OFF_WIDTH-1:0]    vrf_rd_off,
  input  logic [DATA_WIDTH-1:0]   vrf_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_be,
  output logic                    out_start,
  output logic                    out_end,
  output logic                    idle
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW  = VL_WIDTH + 3;
  localparam int EW  = DATA_WIDTH + BPB + 2;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE_C  = PW'(1);
  localparam logic [TW-1:0] BPB_C      = TW'(BPB);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       bytes_left_q, bytes_left_d;
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LAT-1:0] pipe_start_q, pipe_start_d;
  logic [READ_LAT-1:0] pipe_end_q, pipe_end_d;
  logic [BPB-1:0]      pipe_be_q [READ_LAT];
  logic [BPB-1:0]      pipe_be_d [READ_LAT];
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;

  logic                acc_s, pop_s, wr_s;
  logic [TW-1:0]       tot_s;
  logic [BPB-1:0]      be_s;
  logic [EW-1:0]       head_s;

  // Accept/pop strobes and the tail byte-enable of the beat being issued.
  always_comb begin
    req_ready = rst_n & (cnt_q < DEPTH_C);
    out_valid = (fcnt_q != '0);
    acc_s     = req_valid & req_ready & ~flush;
    pop_s     = out_valid & out_ready;
    wr_s      = pipe_vld_q[READ_LAT-1];
    if (req_start) begin
      tot_s = {3'b000, vl} << sew;
    end else begin
      tot_s = bytes_left_q;
    end
    be_s = '0;
    if (tot_s >= BPB_C) begin
      be_s = '1;
    end else begin
      for (int i = 0; i < BPB; i++) begin
        be_s[i] = (TW'(i) < tot_s);
      end
    end
  end

  // Output port drive; the head comes straight from storage and reads 0 when empty.
  always_comb begin
    vrf_rd_en   = acc_s;
    vrf_rd_addr = req_addr;
    vrf_rd_off  = req_off;
    idle        = (cnt_q == '0);
    if (out_valid) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
    out_data  = head_s[EW-1 -: DATA_WIDTH];
    out_be    = head_s[BPB+1:2];
    out_start = head_s[1];
    out_end   = head_s[0];
  end

  // Next-state for credits, byte budget, sideband pipe and FIFO; flush wins.
  always_comb begin
    cnt_d        = cnt_q;
    bytes_left_d = bytes_left_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_start_d = pipe_start_q;
    pipe_end_d   = pipe_end_q;
    pipe_be_d    = pipe_be_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fcnt_d       = fcnt_q;

    pipe_vld_d[0]   = acc_s;
    pipe_start_d[0] = req_start;
    pipe_end_d[0]   = req_end;
    pipe_be_d[0]    = be_s;
    for (int k = 1; k < READ_LAT; k++) begin
      pipe_vld_d[k]   = pipe_vld_q[k-1];
      pipe_start_d[k] = pipe_start_q[k-1];
      pipe_end_d[k]   = pipe_end_q[k-1];
      pipe_be_d[k]    = pipe_be_q[k-1];
    end

    if (flush) begin
      cnt_d        = '0;
      bytes_left_d = '0;
      pipe_vld_d   = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fcnt_d       = '0;
    end else begin
      case ({acc_s, pop_s})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase

      // Byte budget saturates at zero; later beats still flow with be = 0.
      if (acc_s) begin
        if (tot_s >= BPB_C) begin
          bytes_left_d = tot_s - BPB_C;
        end else begin
          bytes_left_d = '0;
        end
      end else begin
        bytes_left_d = bytes_left_q;
      end

      if (wr_s) begin
        mem_d[wr_ptr_q] = {vrf_rd_data, pipe_be_q[READ_LAT-1],
                           pipe_start_q[READ_LAT-1], pipe_end_q[READ_LAT-1]};
        wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + PTR_ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({wr_s, pop_s})
        2'b10:   fcnt_d = fcnt_q + ONE_C;
        2'b01:   fcnt_d = fcnt_q - ONE_C;
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      bytes_left_q <= '0;
      pipe_vld_q   <= '0;
      pipe_start_q <= '0;
      pipe_end_q   <= '0;
      pipe_be_q    <= '{default: '0};
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      bytes_left_q <= bytes_left_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_start_q <= pipe_start_d;
      pipe_end_q   <= pipe_end_d;
      pipe_be_q    <= pipe_be_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
    end
  end

endmodule

// File: doc/vreg_read_stage.md
# vreg_read_stage

Downstream consumer of the vector address generator. Takes the per-beat register/offset stream (`addr`, `off`, `start`, `end`) and issues reads to one vector register file (VRF) read port. Tracks the VRF's fixed read latency with a sideband pipeline, computes per-beat tail byte-enables from `vl`/`sew`, and buffers returned data in a credit-managed FIFO feeding the execution lane with a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 64: VRF port / beat width in bits; `BPB = DATA_WIDTH/8` bytes per beat.
- `ADDR_WIDTH`, 5: vector register address width.
- `OFF_WIDTH`, 8: beat offset within a register.
- `VL_WIDTH`, 15: width of `vl` (element count).
- `READ_LAT`, 1: VRF read latency in cycles; legal values are ≥1.
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ `READ_LAT+2` for full throughput.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `flush` in 1: synchronous abort; drops all in-flight and buffered beats.
- `req_valid` in 1: beat request from the address generator.
- `req_ready` out 1: credit available; a request is accepted when `req_valid & req_ready`.
- `req_addr` in `ADDR_WIDTH`: register address.
- `req_off` in `OFF_WIDTH`: beat offset.
- `req_start` in 1: first beat of an instruction.
- `req_end` in 1: last beat of an instruction.
- `vl` in `VL_WIDTH`: element count, sampled on an accepted `req_start` beat.
- `sew` in 2: element width, sampled with `vl`; 0/1/2/3 → 1/2/4/8 bytes.
- `vrf_rd_en` out 1: VRF read strobe.
- `vrf_rd_addr` out `ADDR_WIDTH`: VRF read address.
- `vrf_rd_off` out `OFF_WIDTH`: VRF read offset.
- `vrf_rd_data` in `DATA_WIDTH`: read data; valid exactly `READ_LAT` cycles after `vrf_rd_en`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out `DATA_WIDTH`: beat data.
- `out_be` out `BPB`: byte enables, where bit i covers byte i.
- `out_start` out 1: first beat of an instruction.
- `out_end` out 1: last beat of an instruction.
- `idle` out 1: no reserved credits and no buffered beats.

## Operation
- **Accept.** `acc = req_valid & req_ready & ~flush`.
  - `vrf_rd_en = acc`, combinational.
  - `vrf_rd_addr`/`vrf_rd_off` pass `req_addr`/`req_off` straight through.
- **Credits.** `cnt` (0..`FIFO_DEPTH`) counts beats in flight plus beats stored.
  - `req_ready = rst_n & (cnt < FIFO_DEPTH)`. It depends only on registered state, never on `out_ready`.
  - Update: `cnt <= cnt + acc - pop`, where `pop = out_valid & out_ready`. Accept and pop in the same cycle leave `cnt` unchanged.
- **Tail byte-enables.** `bytes_left` is a register of width `VL_WIDTH+3`.
  - On an accepted beat, the byte count is `tot = req_start ? (vl << sew) : bytes_left`.
  - `be = (tot >= BPB) ? all-ones : (1<<tot)-1`.
  - Update: `bytes_left <= tot - min(tot, BPB)`.
  - `bytes_left` saturates at 0. Once it is 0, remaining beats carry `be = 0`, but they are still read and delivered.
  - `vl = 0` with `req_start` gives `be = 0` on every beat of that instruction.
- **Sideband pipe.** `READ_LAT` stages carry {valid, be, start, end}. Each stage advances every cycle; the pipe has no stall because credits guarantee FIFO space.
- **FIFO write.** When the last pipe stage is valid, {`vrf_rd_data`, be, start, end} is written at that clock edge.
- **FIFO output.** The head is driven from storage, with no fall-through. `out_valid = !empty`.
- **Flush.** Clears the pipe valids, the FIFO pointers, `cnt` and `bytes_left`.
  - Has priority over accept, write and pop in the same cycle.
  - `vrf_rd_en = 0` during the flush cycle.
- **`idle`.** `idle = (cnt == 0)`.

## Timing
- **Reset.** While `rst_n` is low, all state clears asynchronously:
  - `cnt=0`, FIFO empty, pipe invalid, `bytes_left=0`.
  - Outputs: `out_valid=0`, `req_ready=0`, `vrf_rd_en=0`, `idle=1`.
  - `out_data`/`out_be`/`out_start`/`out_end` read 0.
- **After reset.** `req_ready=1` in the first cycle after `rst_n` is released.
- **Latency.** A beat accepted in cycle t produces `vrf_rd_en` in cycle t, data at `vrf_rd_data` in cycle t+`READ_LAT`, and `out_valid` from cycle t+`READ_LAT`+1.
- **Throughput.** One beat per cycle sustained with `out_ready=1` when `FIFO_DEPTH ≥ READ_LAT+2`.
- **Backpressure.** With `out_ready=0`, exactly `FIFO_DEPTH` beats are accepted, then `req_ready` drops. It rises the cycle after the first pop.
- **Ordering.** Beats leave in acceptance order. `out_start`/`out_end` align with the beats they were accepted with.
- **Reset mid-operation.** All in-flight reads are discarded. Late `vrf_rd_data` is ignored because the pipe valids are cleared.

## Test plan
- **Reset.** Assert `rst_n=0` mid-burst → same cycle: `out_valid=0`, `vrf_rd_en=0`; after release: `req_ready=1`, `idle=1`.
- **Single full beat.** `READ_LAT=1`; accept `req_start=req_end=1`, `vl=8`, `sew=0`, `addr=3`, `off=0` at t=0 → `vrf_rd_en`/`addr=3` at t=0; `out_valid` at t=2 with `out_be=0xFF`, `start=end=1`.
- **Tail mask.** `vl=5`, `sew=2` (20 bytes), 4 beats → `out_be` = 0xFF, 0xFF, 0x0F, 0x00.
- **Backpressure.** `out_ready=0`, continuous `req_valid` → 4 accepts, then `req_ready=0`. Raise `out_ready` → `req_ready=1` one cycle later; data order preserved.
- **Full throughput.** 16 back-to-back beats with `out_ready=1` → `req_ready` never drops; 16 outputs in consecutive cycles.
- **Flush.** Flush with 2 beats in flight and 2 buffered → next cycle `out_valid=0`, `cnt=0`. The next `req_start` reloads `bytes_left` from the new `vl`.
